sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_pkg.sv | 15 +
 rtl/sum_accumulator.sv | 106 ++++++++++
 tb/tb_sum_accumulator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sum_pkg.sv
// Shared definitions for the sum accumulator: FSM state encoding and default sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_COUNT     = 4;
  localparam int DEF_ACC_WIDTH = 11;

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned sums per frame and presents the frame total.
// Latency: total valid one cycle after the last transfer of a frame.
// Backpressure: in_ready drops while a total is pending; released by out_ready.
// Build option: SUM_ACCUMULATOR_SAT_EN selects clamping with a sticky out_sat flag;
// without it the accumulator wraps and out_sat is tied low.
module sum_accumulator
  import sum_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int COUNT     = DEF_COUNT,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH:0]       in_sum,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_sat
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  state_t               r_state;
  state_t               w_next_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_xfer;
  logic                 w_last;
  logic                 w_release;
  logic [ACC_WIDTH-1:0] w_acc_next;

  // A sample is taken only while collecting; DONE blocks upstream entirely.
  assign w_xfer    = in_valid & (r_state == ACCUM);
  assign w_last    = (r_cnt == CNT_W'(COUNT - 1));
  assign w_release = (r_state == DONE) & out_ready;

`ifdef SUM_ACCUMULATOR_SAT_EN
  // One extra bit catches the carry out so the total can be clamped.
  logic [ACC_WIDTH:0] w_sum;
  logic               w_ovf;
  logic               r_sat;

  assign w_sum      = {1'b0, r_acc} + (ACC_WIDTH + 1)'(in_sum);
  assign w_ovf      = w_sum[ACC_WIDTH];
  assign w_acc_next = w_ovf ? '1 : w_sum[ACC_WIDTH-1:0];

  // Sticky clamp flag: set by any overflowing transfer, cleared with the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_release) begin
      r_sat <= 1'b0;
    end else if (w_xfer && w_ovf) begin
      r_sat <= 1'b1;
    end
  end

  assign out_sat = r_sat;
`else
  // Plain modulo-2^ACC_WIDTH accumulation; carry out is simply dropped.
  assign w_acc_next = r_acc + ACC_WIDTH'(in_sum);
  assign out_sat    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: close the frame on its last sample, reopen on the output handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ACCUM:   if (w_xfer && w_last) w_next_state = DONE;
      DONE:    if (out_ready)        w_next_state = ACCUM;
      default:                       w_next_state = ACCUM;
    endcase
  end

  // Accumulator and sample counter; both hold across idle cycles and while DONE waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_acc <= w_acc_next;
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Handshake outputs decode straight from the state register.
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign out_acc   = r_acc;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: default instance plus a 10-bit accumulator instance on shared stimulus.
// Frames come from a vector table; expected totals are queued at drive time and popped at the handshake.
// Hand-written sequences cover backpressure, same-cycle release, out_ready in ACCUM and resets.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [8:0]  in_sum;
  logic        out_ready;
  logic        in_ready,  in_ready_s;
  logic        out_valid, out_valid_s;
  logic [10:0] out_acc;
  logic [9:0]  out_acc_s;
  logic        out_sat,   out_sat_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_sat(out_sat)
  );

  sum_accumulator #(.ACC_WIDTH(10)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .in_ready(in_ready_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_acc(out_acc_s), .out_sat(out_sat_s)
  );

  typedef struct {
    logic [8:0]  s [4];
    int          gap;
    logic [10:0] acc;
    logic [9:0]  acc10;
    logic        sat10;
  } vec_t;

  typedef struct {
    logic [10:0] acc;
    logic [9:0]  acc10;
    logic        sat10;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  function automatic vec_t mk(input int a, input int b, input int c, input int d, input int gap,
                              input int acc, input int acc10_sat, input int sat10,
                              input int acc10_wrap);
    vec_t v;
    v.s[0] = 9'(a); v.s[1] = 9'(b); v.s[2] = 9'(c); v.s[3] = 9'(d);
    v.gap  = gap;
    v.acc  = 11'(acc);
`ifdef SUM_ACCUMULATOR_SAT_EN
    v.acc10 = 10'(acc10_sat);
    v.sat10 = sat10[0];
`else
    v.acc10 = 10'(acc10_wrap);
    v.sat10 = 1'b0;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one sum and return #1 after the edge that accepts it.
  task automatic drive_sum(input logic [8:0] s);
    int n = 0;
    in_valid = 1'b1;
    in_sum   = s;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL drive_timeout: in_ready stuck at %0d, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [10:0] acc, input logic [9:0] acc10, input logic sat10);
    exp_t e;
    e.acc = acc; e.acc10 = acc10; e.sat10 = sat10;
    sb.push_back(e);
  endtask

  // One cycle after the last transfer the total must be on display.
  task automatic check_done_latency();
    chk("latency_out_valid",   out_valid,   1);
    chk("latency_out_valid_s", out_valid_s, 1);
    chk("latency_in_ready",    in_ready,    0);
  endtask

  // Handshake the pending total and compare it with the head of the scoreboard.
  task automatic release_result();
    exp_t e;
    out_ready = 1'b1;
    @(negedge clk);
    if (out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_acc",   out_acc,   e.acc);
      chk("out_sat",   out_sat,   0);
      chk("out_acc_s", out_acc_s, e.acc10);
      chk("out_sat_s", out_sat_s, e.sat10);
    end else begin
      errors++;
      $display("FAIL handshake: out_valid=%0d queue=%0d, required out_valid=1 with a queued result",
               out_valid, sb.size());
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_in_ready",  in_ready,  1);
    chk("release_out_valid", out_valid, 0);
  endtask

  task automatic run_frame(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
          chk("gap_out_valid", out_valid, 0);
          chk("gap_in_ready",  in_ready,  1);
        end
      end
      drive_sum(v.s[k]);
    end
    in_valid = 1'b0;
    push_exp(v.acc, v.acc10, v.sat10);
    check_done_latency();
    release_result();
  endtask

  initial begin
    vecs[0] = mk( 10,  20,  30,  40, 0,  100,  100, 0,  100);
    vecs[1] = mk(511, 511, 511, 511, 2, 2044, 1023, 1, 1020);
    vecs[2] = mk(  0,   0,   0,   0, 0,    0,    0, 0,    0);
    vecs[3] = mk(500, 500, 500, 500, 1, 2000, 1023, 1,  976);
    vecs[4] = mk(300, 300, 300, 300, 0, 1200, 1023, 1,  176);
    vecs[5] = mk(  1,   2,   3,   4, 0,   10,   10, 0,   10);
    vecs[6] = mk(511, 511,   1,   0, 0, 1023, 1023, 0, 1023);
    vecs[7] = mk(511, 511, 511,   0, 3, 1533, 1023, 1,  509);

    rst = 1'b1; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_acc",   out_acc,   0);
    chk("reset_out_sat",   out_sat,   0);
    chk("reset_out_acc_s", out_acc_s, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // Backpressure: upstream keeps offering while the total waits.
    drive_sum(50); drive_sum(60); drive_sum(70); drive_sum(80);
    push_exp(11'd260, 10'd260, 1'b0);
    check_done_latency();
    in_valid = 1'b1; in_sum = 9'd99;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_in_ready",  in_ready,  0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_acc",   out_acc,   260);
    end

    // Release and new input in the same cycle: the sum waits one cycle.
    in_sum = 9'd5;
    release_result();
    chk("same_cycle_not_taken", out_acc, 0);
    drive_sum(5); drive_sum(6); drive_sum(7); drive_sum(8);
    in_valid = 1'b0;
    push_exp(11'd26, 10'd26, 1'b0);
    check_done_latency();
    release_result();

    // out_ready high during collection changes nothing.
    out_ready = 1'b1;
    drive_sum(2); drive_sum(3);
    out_ready = 1'b0;
    drive_sum(4); drive_sum(5);
    in_valid = 1'b0;
    push_exp(11'd14, 10'd14, 1'b0);
    check_done_latency();
    release_result();

    // Mid-frame reset discards the partial total asynchronously.
    drive_sum(100); drive_sum(200);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_acc",   out_acc,   0);
    chk("async_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_release_in_ready", in_ready, 1);
    run_frame(mk(1, 2, 3, 4, 0, 10, 10, 0, 10));

    // Reset while a total is pending drops it.
    drive_sum(9); drive_sum(9); drive_sum(9); drive_sum(9);
    in_valid = 1'b0;
    chk("pending_out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("pending_dropped_valid", out_valid, 0);
    chk("pending_dropped_acc",   out_acc,   0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(mk(7, 0, 0, 1, 1, 8, 8, 0, 8));

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
